// File: rtl/twowire_pkg.sv
// Shared definitions for the Two-Wire Debug APB fabric: FSM encoding and
// the address width derivation that the DTM core also uses.
package twowire_pkg;

   localparam int W_STATE = 3;

   typedef enum logic [W_STATE-1:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_RESP   = 3'd3,
      ST_ERR    = 3'd4
   } apb_state_e;

   function automatic int w_addr(input int asize);
      return 8 * (1 + asize);
   endfunction

endpackage

// File: rtl/twowire_apb_split_if.sv
// APB3 bus bundle with N_SEL select lanes; N_SEL=1 on the DTM side,
// N_SEL=N_TGT on the target side (per-lane pready/pslverr/prdata).
interface twowire_apb_split_if #(
   parameter int W_ADDR = 8,
   parameter int N_SEL  = 1
);
   logic [W_ADDR-1:0]    paddr;
   logic [N_SEL-1:0]     psel;
   logic                 penable;
   logic                 pwrite;
   logic [31:0]          pwdata;
   logic [N_SEL-1:0]     pready;
   logic [N_SEL-1:0]     pslverr;
   logic [32*N_SEL-1:0]  prdata;

   modport master (
      output paddr, psel, penable, pwrite, pwdata,
      input  pready, pslverr, prdata
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata,
      output pready, pslverr, prdata
   );
endinterface

// File: rtl/twowire_apb_decode.sv
// Base/mask address decoder; the lowest matching target index wins.
module twowire_apb_decode #(
   parameter int                        N_TGT    = 2,
   parameter int                        W_ADDR   = 8,
   parameter logic [N_TGT*W_ADDR-1:0]   TGT_BASE = '0,
   parameter logic [N_TGT*W_ADDR-1:0]   TGT_MASK = '0
) (
   input  logic [W_ADDR-1:0] addr,
   output logic              hit,
   output logic [3:0]        idx
);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      // Walk downward so the lowest matching index is the last one written.
      for (int i = N_TGT - 1; i >= 0; i--) begin
         if ((addr & TGT_MASK[i*W_ADDR +: W_ADDR]) == TGT_BASE[i*W_ADDR +: W_ADDR]) begin
            hit = 1'b1;
            idx = 4'(i);
         end
      end
   end

endmodule

// File: rtl/twowire_apb_split.sv
// APB3 fan-out from the DTM requester to N_TGT targets, with unmapped-address
// error completion and a per-access watchdog so the DTM bus cannot lock up.
//
// state  | meaning
// IDLE   | waiting for an upstream setup phase
// SETUP  | downstream setup phase to the decoded target
// ACCESS | downstream access phase, waiting on pready or watchdog
// RESP   | upstream completion with captured response
// ERR    | upstream error completion for an unmapped address
module twowire_apb_split
   import twowire_pkg::*;
#(
   parameter int                               ASIZE    = 0,
   parameter int                               N_TGT    = 2,
   parameter logic [N_TGT*8*(1+ASIZE)-1:0]     TGT_BASE = '0,
   parameter logic [N_TGT*8*(1+ASIZE)-1:0]     TGT_MASK = '0,
   parameter int                               TIMEOUT  = 256
) (
   input  logic                   dck,
   input  logic                   drst_n,
   twowire_apb_split_if.slave     src,
   twowire_apb_split_if.master    dst,
   output logic                   timeout_evt,
   output logic [3:0]             timeout_tgt
);

   localparam int W_ADDR = w_addr(ASIZE);
   localparam int W_CNT  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
   localparam logic [W_CNT-1:0] CNT_MAX  = '1;

   apb_state_e         state_q, state_nxt;
   logic [3:0]         idx_q, idx_nxt;
   logic [W_ADDR-1:0]  paddr_q;
   logic [31:0]        pwdata_q;
   logic               pwrite_q;
   logic [W_CNT-1:0]   cnt_q;

   logic [N_TGT-1:0]   dst_psel_q;
   logic               dst_penable_q;
   logic               src_pready_q, src_pslverr_q;
   logic [31:0]        src_prdata_q;
   logic               evt_q;
   logic [3:0]         tgt_q;

   logic               dec_hit;
   logic [3:0]         dec_idx;
   logic               setup_seen;
   logic               sel_ready, sel_err;
   logic [31:0]        sel_rdata;
   logic [N_TGT-1:0]   psel_onehot;
   logic               wd_fire;
   logic               acc_to_resp;
   logic               slverr_nxt;
   logic [31:0]        rdata_nxt;
   logic               evt_nxt;

   twowire_apb_decode #(
      .N_TGT    (N_TGT),
      .W_ADDR   (W_ADDR),
      .TGT_BASE (TGT_BASE),
      .TGT_MASK (TGT_MASK)
   ) u_decode (
      .addr (src.paddr),
      .hit  (dec_hit),
      .idx  (dec_idx)
   );

   assign setup_seen = src.psel[0] && !src.penable;
   assign idx_nxt    = (state_q == ST_IDLE && setup_seen) ? dec_idx : idx_q;

   always_comb begin
      sel_ready   = 1'b0;
      sel_err     = 1'b0;
      sel_rdata   = '0;
      psel_onehot = '0;
      for (int i = 0; i < N_TGT; i++) begin
         if (idx_q == 4'(i)) begin
            sel_ready = dst.pready[i];
            sel_err   = dst.pslverr[i];
            sel_rdata = dst.prdata[32*i +: 32];
         end
         psel_onehot[i] = (idx_nxt == 4'(i));
      end
   end

   // A target answering in the expiry cycle beats the watchdog.
   assign wd_fire = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !sel_ready;

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:   if (setup_seen) state_nxt = dec_hit ? ST_SETUP : ST_ERR;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: if (sel_ready || wd_fire) state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         ST_ERR:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      // Requester gave up: drop everything silently.
      if (state_q != ST_IDLE && !src.psel[0]) state_nxt = ST_IDLE;

      acc_to_resp = (state_q == ST_ACCESS) && (state_nxt == ST_RESP);
      evt_nxt     = acc_to_resp && !sel_ready;
      slverr_nxt  = (state_nxt == ST_ERR) || (acc_to_resp && (sel_ready ? sel_err : 1'b1));
      rdata_nxt   = (acc_to_resp && sel_ready && !pwrite_q) ? sel_rdata : 32'h0;
   end

   always_ff @(posedge dck) begin
      if (!drst_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pwrite_q      <= 1'b0;
         cnt_q         <= '0;
         dst_psel_q    <= '0;
         dst_penable_q <= 1'b0;
         src_pready_q  <= 1'b0;
         src_pslverr_q <= 1'b0;
         src_prdata_q  <= '0;
         evt_q         <= 1'b0;
         tgt_q         <= '0;
      end else begin
         state_q <= state_nxt;
         if (state_q == ST_IDLE && setup_seen) begin
            paddr_q  <= src.paddr;
            pwdata_q <= src.pwdata;
            pwrite_q <= src.pwrite;
            idx_q    <= dec_idx;
         end
         if (state_q == ST_SETUP)
            cnt_q <= '0;
         else if (state_q == ST_ACCESS && !sel_ready && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
         dst_psel_q    <= (state_nxt == ST_SETUP || state_nxt == ST_ACCESS) ? psel_onehot : '0;
         dst_penable_q <= (state_nxt == ST_ACCESS);
         src_pready_q  <= (state_nxt == ST_RESP || state_nxt == ST_ERR);
         src_pslverr_q <= slverr_nxt;
         src_prdata_q  <= rdata_nxt;
         evt_q         <= evt_nxt;
         if (evt_nxt) tgt_q <= idx_q;
      end
   end

   assign dst.psel       = dst_psel_q;
   assign dst.penable    = dst_penable_q;
   assign dst.pwrite     = pwrite_q;
   assign dst.paddr      = paddr_q;
   assign dst.pwdata     = pwdata_q;
   assign src.pready[0]  = src_pready_q;
   assign src.pslverr[0] = src_pslverr_q;
   assign src.prdata     = src_prdata_q;
   assign timeout_evt    = evt_q;
   assign timeout_tgt    = tgt_q;

endmodule

// File: tb/tb_twowire_apb_split.sv
// Scoreboard bench for twowire_apb_split: directed transfers push expected
// responses, a monitor pops and compares whenever src pready is seen.
module tb_twowire_apb_split;

   localparam logic [15:0] BASE = {8'h80, 8'h00};
   localparam logic [15:0] MASK = {8'hc0, 8'hc0};

   logic       dck = 1'b0;
   logic       drst_n = 1'b0;
   logic       timeout_evt;
   logic [3:0] timeout_tgt;

   twowire_apb_split_if #(.W_ADDR(8), .N_SEL(1)) src ();
   twowire_apb_split_if #(.W_ADDR(8), .N_SEL(2)) dst ();

   twowire_apb_split #(
      .ASIZE(0), .N_TGT(2), .TGT_BASE(BASE), .TGT_MASK(MASK), .TIMEOUT(4)
   ) dut (
      .dck         (dck),
      .drst_n      (drst_n),
      .src         (src),
      .dst         (dst),
      .timeout_evt (timeout_evt),
      .timeout_tgt (timeout_tgt)
   );

   always #5 dck = ~dck;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          pen;
      int          evt;
      logic [1:0]  psel;
      logic [3:0]  tgt;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          setup_cyc = 0;
   int          pen_cnt = 0;
   int          evt_cnt = 0;
   logic [1:0]  psel_or = '0;

   int          tgt_wait [2];
   logic [31:0] tgt_rdata[2];
   logic        tgt_err  [2];
   int          acc_cnt  [2];
   logic [7:0]  exp_addr;
   logic        exp_write;
   logic [31:0] exp_wdata;
   logic [1:0]  exp_psel;

   always @(posedge dck) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Target model: ready after tgt_wait access cycles; checks the broadcast bus.
   always @(negedge dck) begin
      for (int t = 0; t < 2; t++) begin
         if (dst.psel[t] && dst.penable) begin
            check("dst_psel", 32'(dst.psel), 32'(exp_psel));
            check("dst_paddr", 32'(dst.paddr), 32'(exp_addr));
            check("dst_pwrite", 32'(dst.pwrite), 32'(exp_write));
            if (exp_write) check("dst_pwdata", dst.pwdata, exp_wdata);
            dst.pready[t]           = (acc_cnt[t] == tgt_wait[t]);
            dst.pslverr[t]          = tgt_err[t] && (acc_cnt[t] == tgt_wait[t]);
            dst.prdata[32*t +: 32]  = tgt_rdata[t];
            acc_cnt[t]++;
         end else begin
            dst.pready[t]           = 1'b0;
            dst.pslverr[t]          = 1'b0;
            dst.prdata[32*t +: 32]  = 32'h0;
            acc_cnt[t]              = 0;
         end
      end
   end

   always @(negedge dck) begin
      if (dst.penable) pen_cnt++;
      if (timeout_evt) evt_cnt++;
      psel_or = psel_or | dst.psel;
      if (src.pready[0]) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pready: got 1 expected 0");
         end else begin
            mon_e = sb_q.pop_front();
            check("latency", 32'(cyc - setup_cyc), 32'(mon_e.lat));
            check("prdata", src.prdata, mon_e.rdata);
            check("pslverr", 32'(src.pslverr[0]), 32'(mon_e.err));
            check("penable_cycles", 32'(pen_cnt), 32'(mon_e.pen));
            check("timeout_evt_count", 32'(evt_cnt), 32'(mon_e.evt));
            check("dst_psel_seen", 32'(psel_or), 32'(mon_e.psel));
            check("timeout_tgt", 32'(timeout_tgt), 32'(mon_e.tgt));
         end
      end
   end

   task automatic start_setup(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                              input logic [1:0] e_psel);
      exp_addr  = addr;
      exp_write = wr;
      exp_wdata = wdata;
      exp_psel  = e_psel;
      setup_cyc = cyc;
      pen_cnt   = 0;
      evt_cnt   = 0;
      psel_or   = '0;
      src.paddr   = addr;
      src.pwrite  = wr;
      src.pwdata  = wdata;
      src.psel    = 1'b1;
      src.penable = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                       input int e_pen, input int e_evt, input logic [1:0] e_psel,
                       input logic [3:0] e_tgt);
      exp_t e;
      int   n;
      logic seen;
      e = '{rdata: e_rdata, err: e_err, lat: e_lat, pen: e_pen, evt: e_evt,
            psel: e_psel, tgt: e_tgt};
      sb_q.push_back(e);
      start_setup(addr, wr, wdata, e_psel);
      @(posedge dck); #1 src.penable = 1'b1;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge dck);
         if (src.pready[0]) seen = 1'b1;
         n++;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL pready_wait: got no pready expected pready within 40 cycles");
         void'(sb_q.pop_front());
      end
      @(posedge dck); #1;
      src.psel    = 1'b0;
      src.penable = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dst_psel"}, 32'(dst.psel), 32'h0);
      check({tag, "_dst_penable"}, 32'(dst.penable), 32'h0);
      check({tag, "_dst_pwrite"}, 32'(dst.pwrite), 32'h0);
      check({tag, "_dst_paddr"}, 32'(dst.paddr), 32'h0);
      check({tag, "_dst_pwdata"}, dst.pwdata, 32'h0);
      check({tag, "_src_pready"}, 32'(src.pready[0]), 32'h0);
      check({tag, "_src_pslverr"}, 32'(src.pslverr[0]), 32'h0);
      check({tag, "_src_prdata"}, src.prdata, 32'h0);
      check({tag, "_timeout_evt"}, 32'(timeout_evt), 32'h0);
      check({tag, "_timeout_tgt"}, 32'(timeout_tgt), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got still running expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      src.paddr = '0; src.pwrite = 1'b0; src.pwdata = '0;
      src.psel = 1'b0; src.penable = 1'b0;
      tgt_wait[0] = 0;  tgt_wait[1] = 0;
      tgt_rdata[0] = 32'hdeadbeef; tgt_rdata[1] = 32'hcafef00d;
      tgt_err[0] = 1'b0; tgt_err[1] = 1'b0;
      acc_cnt[0] = 0; acc_cnt[1] = 0;
      exp_addr = '0; exp_write = 1'b0; exp_wdata = '0; exp_psel = '0;

      repeat (3) @(posedge dck);
      @(negedge dck);
      check_all_zero("reset");
      @(posedge dck); #1 drst_n = 1'b1;
      @(posedge dck); #1;

      // Zero-wait read on target 0.
      xfer(8'h05, 1'b0, 32'h0, 32'hdeadbeef, 1'b0, 3, 1, 0, 2'b01, 4'd0);
      // Write to target 1 with three wait states; read data must not leak.
      tgt_wait[1] = 3;
      xfer(8'h85, 1'b1, 32'h12345678, 32'h0, 1'b0, 6, 4, 0, 2'b10, 4'd0);
      // Unmapped.
      xfer(8'h45, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 0, 2'b00, 4'd0);
      // Watchdog on target 0.
      tgt_wait[0] = 255;
      xfer(8'h05, 1'b0, 32'h0, 32'h0, 1'b1, 6, 4, 1, 2'b01, 4'd0);
      // Ready in the last watchdog cycle wins.
      tgt_wait[0] = 3;
      xfer(8'h05, 1'b0, 32'h0, 32'hdeadbeef, 1'b0, 6, 4, 0, 2'b01, 4'd0);
      // Target error, then a clean back-to-back transfer.
      tgt_wait[1] = 0;
      tgt_err[1]  = 1'b1;
      xfer(8'h85, 1'b0, 32'h0, 32'hcafef00d, 1'b1, 3, 1, 0, 2'b10, 4'd0);
      tgt_err[1]  = 1'b0;
      xfer(8'hbf, 1'b0, 32'h0, 32'hcafef00d, 1'b0, 3, 1, 0, 2'b10, 4'd0);
      // Watchdog on target 1, then timeout_tgt holds through a clean transfer.
      tgt_wait[1] = 255;
      xfer(8'h85, 1'b0, 32'h0, 32'h0, 1'b1, 6, 4, 1, 2'b10, 4'd1);
      tgt_wait[0] = 0;
      xfer(8'h3f, 1'b0, 32'h0, 32'hdeadbeef, 1'b0, 3, 1, 0, 2'b01, 4'd1);

      // Reset during ACCESS.
      tgt_wait[0] = 255;
      start_setup(8'h05, 1'b1, 32'ha5a5a5a5, 2'b01);
      @(posedge dck); #1 src.penable = 1'b1;
      @(posedge dck); #1 drst_n = 1'b0;
      @(posedge dck);
      @(negedge dck);
      check_all_zero("midreset");
      @(posedge dck); #1;
      drst_n = 1'b1;
      src.psel = 1'b0;
      src.penable = 1'b0;
      @(posedge dck); #1;

      // Upstream abort during ACCESS.
      start_setup(8'h05, 1'b0, 32'h0, 2'b01);
      @(posedge dck); #1 src.penable = 1'b1;
      @(posedge dck); #1;
      src.psel = 1'b0;
      src.penable = 1'b0;
      @(posedge dck);
      @(negedge dck);
      check("abort_dst_psel", 32'(dst.psel), 32'h0);
      check("abort_dst_penable", 32'(dst.penable), 32'h0);
      check("abort_src_pready", 32'(src.pready[0]), 32'h0);
      repeat (6) @(negedge dck);
      check("abort_penable_cycles", 32'(pen_cnt), 32'd1);
      check("abort_timeout_evt", 32'(evt_cnt), 32'd0);
      @(posedge dck); #1;

      // Back in IDLE: a normal transfer still has two wait states.
      tgt_wait[0] = 0;
      xfer(8'h05, 1'b0, 32'h0, 32'hdeadbeef, 1'b0, 3, 1, 0, 2'b01, 4'd0);

      repeat (3) @(posedge dck);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/twowire_apb_split.md
# twowire_apb_split

Downstream APB3 fabric stage for the Two-Wire Debug DTM. It takes the DTM core's single APB3 requester port and decodes each transfer to one of N_TGT APB3 targets by base/mask match. Unmapped addresses complete immediately with an error, and a per-access watchdog aborts hung targets with an error. As a result, the DTM's sticky busfault flag fires and the DTM bus never locks up.

## Interface
- `ASIZE`, default 0: address width selector; W_ADDR = 8*(1+ASIZE), matching the DTM core.
- `N_TGT`, default 2: number of downstream targets, 1..16.
- `TGT_BASE`, default {N_TGT{W_ADDR'h0}}: packed per-target base address, target i at [i*W_ADDR +: W_ADDR].
- `TGT_MASK`, default {N_TGT{W_ADDR'h0}}: packed per-target compare mask, same layout.
- `TIMEOUT`, default 256: maximum number of downstream access-phase cycles before abort; 0 disables the watchdog.
- `dck`, input, 1: clock.
- `drst_n`, input, 1: reset. Synchronous, active-low.
- `src_paddr`, input, W_ADDR: upstream address.
- `src_psel`, `src_penable`, `src_pwrite`, input, 1 each: upstream APB3 controls.
- `src_pwdata`, input, 32: upstream write data.
- `src_pready`, `src_pslverr`, output, 1 each: upstream response. Registered.
- `src_prdata`, output, 32: upstream read data. Registered.
- `dst_psel`, output, N_TGT: one-hot target select.
- `dst_penable`, `dst_pwrite`, output, 1 each: broadcast to all targets.
- `dst_paddr`, output, W_ADDR: broadcast address, latched.
- `dst_pwdata`, output, 32: broadcast write data, latched.
- `dst_pready`, `dst_pslverr`, input, N_TGT each: per-target responses.
- `dst_prdata`, input, 32*N_TGT: per-target read data, target i at [32*i +: 32].
- `timeout_evt`, output, 1: single-cycle pulse on watchdog abort.
- `timeout_tgt`, output, 4: index of the aborted target. Holds until the next abort.

## Operation
- Decode rule: target i hits when (src_paddr & TGT_MASK[i]) == TGT_BASE[i]. The lowest index wins; no hit means unmapped.
- FSM states: IDLE, SETUP, ACCESS, RESP, ERR.
- **IDLE**
  - On src_psel && !src_penable: latch paddr, pwdata, pwrite and the hit index.
  - Go to SETUP on a hit; go to ERR if unmapped.
  - src_psel && src_penable seen in IDLE (no setup was observed) is ignored until src_psel drops.
- **SETUP**: dst_psel[idx]=1, dst_penable=0. Clear the watchdog counter. Go to ACCESS.
- **ACCESS**
  - dst_psel[idx]=1, dst_penable=1.
  - If dst_pready[idx]: capture dst_prdata[idx] and dst_pslverr[idx], deassert dst_psel/penable, go to RESP.
  - Otherwise increment the counter.
  - If TIMEOUT != 0 and the counter == TIMEOUT-1 with pready still low: deassert dst_psel/penable, pulse timeout_evt, load timeout_tgt=idx, go to RESP with pslverr=1 and prdata=0.
  - pready arriving on the same cycle as the timeout condition wins; no timeout is raised.
- **RESP**: src_pready=1, src_pslverr and src_prdata driven for one cycle. Go to IDLE.
- **ERR**: src_pready=1, src_pslverr=1, src_prdata=0 for one cycle. Go to IDLE.
- Writes: on a write, the captured prdata is ignored and src_prdata is driven 0.
- src_prdata is 0 in every cycle except RESP.
- Upstream abort: if src_psel is low in any state other than IDLE, the next cycle drops all dst_psel/dst_penable and returns to IDLE. No response is given and no timeout is raised.
- Counter width: clog2(TIMEOUT+1), saturating.

## Timing
- Reset (drst_n low at a dck edge) forces:
  - state IDLE;
  - all dst_psel, dst_penable, dst_pwrite, dst_paddr, dst_pwdata = 0;
  - src_pready, src_pslverr, src_prdata = 0;
  - timeout_evt = 0, timeout_tgt = 0.
- Reset mid-transfer drops dst_psel on that edge.
- Mapped transfer, zero-wait target, with upstream setup at cycle 0:
  - dst setup at cycle 1;
  - dst access at cycle 2;
  - src_pready=1 at cycle 3.
  - This gives 2 upstream wait states. Each target wait state adds one.
- Unmapped transfer: src_pready=1 at cycle 1, i.e. zero upstream wait states.
- Watchdog abort: the downstream access phase lasts exactly TIMEOUT cycles; src_pready follows one cycle later.
- Back-to-back transfers: a new upstream setup is accepted in the IDLE cycle immediately after RESP or ERR.

## Structure
- Shared package `twowire_pkg`: FSM state localparams (W_STATE=3) and the W_ADDR derivation from ASIZE. The DTM core reuses the latter.
- Sub-module `twowire_apb_decode`: purely combinational base/mask priority decoder. Outputs a hit flag and the index. Parameters N_TGT, W_ADDR, TGT_BASE, TGT_MASK.

## Test plan
- Read, zero-wait target. N_TGT=2, BASE={8'h80,8'h00}, MASK={8'hc0,8'hc0}. Read 8'h05, target 0 returns 32'hdeadbeef → dst_psel=2'b01, src_pready at cycle 3, src_prdata=32'hdeadbeef, pslverr=0.
- Write with wait states. Write 8'h85 with data 32'h12345678, target 1 stalls 3 cycles → dst_psel=2'b10, dst_pwdata=32'h12345678 held throughout, src_pready at cycle 6.
- Unmapped address. Read 8'h45 → src_pready=1 and pslverr=1 at cycle 1, prdata=0, no dst_psel asserted.
- Watchdog. TIMEOUT=4, target 0 never ready → dst_penable high for exactly 4 cycles, timeout_evt pulses once, timeout_tgt=0, then src_pready=1 with pslverr=1. Repeat the test with pready arriving on the 4th cycle → normal completion, no timeout_evt.
- Target error. Target 1 returns pready=1 with pslverr=1 → src_pslverr=1 in RESP. The next transfer, issued back-to-back, completes cleanly.
- Reset and upstream abort.
  - Assert drst_n low during ACCESS → all outputs 0 on the next edge.
  - Separately, drop src_psel during ACCESS → dst_psel=0 on the next cycle, no src_pready, FSM in IDLE.
